// File: rtl/tlul_pkg.sv
// Shared TL-UL constants and the responder FSM state type.
// No logic; imported by the TL-UL peripheral blocks.
// No handshake of its own.
package tlul_pkg;

  localparam logic [2:0] TL_PUT_FULL        = 3'd0;
  localparam logic [2:0] TL_PUT_PARTIAL     = 3'd1;
  localparam logic [2:0] TL_GET             = 3'd4;
  localparam logic [2:0] TL_ACCESS_ACK      = 3'd0;
  localparam logic [2:0] TL_ACCESS_ACK_DATA = 3'd1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RESP = 1'b1
  } tl_state_e;

endpackage

// File: rtl/tlul_sync_2ff.sv
// Two-flop synchronizer for asynchronous level inputs, parameterized width.
// Latency: 2 clk cycles from input change to q.
// Backpressure: none, free-running.
module tlul_sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta_q <= '0;
      q      <= '0;
    end else begin
      meta_q <= d;
      q      <= meta_q;
    end
  end

endmodule

// File: rtl/tlul_gpio_slave.sv
// TL-UL responder for a 5-register GPIO block with rising-edge interrupt.
// Latency: D beat valid the cycle after A accept; writes take effect at the accept edge.
// Backpressure: single outstanding request; a_ready stays low until the D beat is taken.
module tlul_gpio_slave
  import tlul_pkg::*;
#(
  parameter int                  ADDR_WIDTH   = 32,
  parameter int                  DATA_WIDTH   = 32,
  parameter int                  MASK_WIDTH   = DATA_WIDTH / 8,
  parameter int                  SIZE_WIDTH   = 3,
  parameter int                  SRC_WIDTH    = 2,
  parameter int                  SINK_WIDTH   = 1,
  parameter int                  OPCODE_WIDTH = 3,
  parameter int                  PARAM_WIDTH  = 3,
  parameter int                  GPIO_WIDTH   = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    a_valid,
  output logic                    a_ready,
  input  logic [OPCODE_WIDTH-1:0] a_opcode,
  input  logic [PARAM_WIDTH-1:0]  a_param,
  input  logic [SIZE_WIDTH-1:0]   a_size,
  input  logic [SRC_WIDTH-1:0]    a_source,
  input  logic [ADDR_WIDTH-1:0]   a_address,
  input  logic [MASK_WIDTH-1:0]   a_mask,
  input  logic [DATA_WIDTH-1:0]   a_data,
  output logic                    d_valid,
  input  logic                    d_ready,
  output logic [OPCODE_WIDTH-1:0] d_opcode,
  output logic [PARAM_WIDTH-1:0]  d_param,
  output logic [SIZE_WIDTH-1:0]   d_size,
  output logic [SRC_WIDTH-1:0]    d_source,
  output logic [SINK_WIDTH-1:0]   d_sink,
  output logic [DATA_WIDTH-1:0]   d_data,
  output logic                    d_error,
  input  logic [GPIO_WIDTH-1:0]   gpio_in,
  output logic [GPIO_WIDTH-1:0]   gpio_out,
  output logic [GPIO_WIDTH-1:0]   gpio_oe,
  output logic                    intr
);

  localparam logic [2:0] REG_DATA_OUT    = 3'd0;
  localparam logic [2:0] REG_DATA_IN     = 3'd1;
  localparam logic [2:0] REG_OE          = 3'd2;
  localparam logic [2:0] REG_INTR_STATE  = 3'd3;
  localparam logic [2:0] REG_INTR_ENABLE = 3'd4;

  tl_state_e state_q, state_d;

  logic [GPIO_WIDTH-1:0] data_out_q, oe_q, intr_state_q, intr_en_q;
  logic [GPIO_WIDTH-1:0] sync_q, hist_q, rise, clr;
  logic [GPIO_WIDTH-1:0] wmask, wval;
  logic [DATA_WIDTH-1:0] bmask, rdata;
  logic [2:0]            offset;
  logic                  a_fire, d_fire, is_get, is_put, req_err, wr_en;
  logic                  unused_a_param;

  assign unused_a_param = ^a_param;

  assign a_ready = (state_q == ST_IDLE);
  assign d_valid = (state_q == ST_RESP);
  assign a_fire  = a_valid && a_ready;
  assign d_fire  = d_valid && d_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (a_fire) state_d = ST_RESP;
      ST_RESP: if (d_fire) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Request decode and error classification; any error suppresses side effects.
  assign offset = a_address[4:2];
  assign is_get = (a_opcode == OPCODE_WIDTH'(TL_GET));
  assign is_put = (a_opcode == OPCODE_WIDTH'(TL_PUT_FULL)) ||
                  (a_opcode == OPCODE_WIDTH'(TL_PUT_PARTIAL));

  always_comb begin
    req_err = 1'b0;
    if (!(is_get || is_put))                                           req_err = 1'b1;
    if (a_address[ADDR_WIDTH-1:5] != BASE_ADDR[ADDR_WIDTH-1:5])        req_err = 1'b1;
    if (offset > REG_INTR_ENABLE)                                      req_err = 1'b1;
    if (a_size > SIZE_WIDTH'(2))                                       req_err = 1'b1;
    if ((a_size == SIZE_WIDTH'(2)) && (a_address[1:0] != 2'b00))       req_err = 1'b1;
    if (is_put && (offset == REG_DATA_IN))                             req_err = 1'b1;
  end

  assign wr_en = a_fire && is_put && !req_err;

  always_comb begin
    bmask = '0;
    for (int i = 0; i < MASK_WIDTH; i++) bmask[8*i +: 8] = {8{a_mask[i]}};
  end

  assign wmask = bmask[GPIO_WIDTH-1:0];
  assign wval  = a_data[GPIO_WIDTH-1:0] & wmask;
  assign clr   = (wr_en && offset == REG_INTR_STATE) ? wval : '0;
  assign rise  = sync_q & ~hist_q;

  always_comb begin
    rdata = '0;
    case (offset)
      REG_DATA_OUT:    rdata = DATA_WIDTH'(data_out_q);
      REG_DATA_IN:     rdata = DATA_WIDTH'(sync_q);
      REG_OE:          rdata = DATA_WIDTH'(oe_q);
      REG_INTR_STATE:  rdata = DATA_WIDTH'(intr_state_q);
      REG_INTR_ENABLE: rdata = DATA_WIDTH'(intr_en_q);
      default:         rdata = '0;
    endcase
  end

  tlul_sync_2ff #(.WIDTH(GPIO_WIDTH)) u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (gpio_in),
    .q       (sync_q)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_out_q   <= '0;
      oe_q         <= '0;
      intr_state_q <= '0;
      intr_en_q    <= '0;
      hist_q       <= '0;
      intr         <= 1'b0;
    end else begin
      if (wr_en && offset == REG_DATA_OUT)    data_out_q <= (data_out_q & ~wmask) | wval;
      if (wr_en && offset == REG_OE)          oe_q       <= (oe_q & ~wmask) | wval;
      if (wr_en && offset == REG_INTR_ENABLE) intr_en_q  <= (intr_en_q & ~wmask) | wval;
      // Hardware set is OR-ed after the clear so a coincident edge is never lost.
      intr_state_q <= (intr_state_q & ~clr) | rise;
      hist_q       <= sync_q;
      intr         <= |(intr_state_q & intr_en_q);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      d_opcode <= '0;
      d_size   <= '0;
      d_source <= '0;
      d_data   <= '0;
      d_error  <= 1'b0;
    end else if (a_fire) begin
      d_opcode <= is_get ? OPCODE_WIDTH'(TL_ACCESS_ACK_DATA) : OPCODE_WIDTH'(TL_ACCESS_ACK);
      d_size   <= a_size;
      d_source <= a_source;
      d_data   <= (is_get && !req_err) ? rdata : '0;
      d_error  <= req_err;
    end
  end

  assign d_param  = '0;
  assign d_sink   = '0;
  assign gpio_out = data_out_q;
  assign gpio_oe  = oe_q;

endmodule

// File: tb/tb_tlul_gpio_slave.sv
// Scoreboard bench for tlul_gpio_slave: directed scenarios then randomized traffic.
// Expected D beats come from a register-level model; a negedge monitor checks them.
module tb_tlul_gpio_slave;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        a_valid, a_ready;
  logic [2:0]  a_opcode, a_param, a_size;
  logic [1:0]  a_source;
  logic [31:0] a_address, a_data;
  logic [3:0]  a_mask;
  logic        d_valid, d_ready;
  logic [2:0]  d_opcode, d_param, d_size;
  logic [1:0]  d_source;
  logic [0:0]  d_sink;
  logic [31:0] d_data;
  logic        d_error;
  logic [31:0] gpio_in, gpio_out, gpio_oe;
  logic        intr;

  always #5 clk = ~clk;

  tlul_gpio_slave dut (
    .clk(clk), .reset_n(reset_n),
    .a_valid(a_valid), .a_ready(a_ready), .a_opcode(a_opcode), .a_param(a_param),
    .a_size(a_size), .a_source(a_source), .a_address(a_address), .a_mask(a_mask),
    .a_data(a_data),
    .d_valid(d_valid), .d_ready(d_ready), .d_opcode(d_opcode), .d_param(d_param),
    .d_size(d_size), .d_source(d_source), .d_sink(d_sink), .d_data(d_data),
    .d_error(d_error),
    .gpio_in(gpio_in), .gpio_out(gpio_out), .gpio_oe(gpio_oe), .intr(intr)
  );

  typedef struct packed {
    logic [2:0]  opcode;
    logic        err;
    logic [31:0] data;
    logic [1:0]  src;
    logic [2:0]  size;
  } rsp_t;

  rsp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  int   rdy_mode = 2;  // 0 random, 1 held low, 2 held high
  logic in_reset = 1'b0;

  // Reference register file
  logic [31:0] m_out, m_oe, m_is, m_ie, m_din;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_out = 0; m_oe = 0; m_is = 0; m_ie = 0; m_din = 0;
  endtask

  function automatic rsp_t model_access(input logic [2:0] op, input logic [31:0] addr,
                                        input logic [3:0] mask, input logic [31:0] data,
                                        input logic [1:0] src, input logic [2:0] size);
    rsp_t        r;
    logic [31:0] bm;
    int          off;
    logic        err;
    off = int'(addr[4:2]);
    err = !(op == 3'd0 || op == 3'd1 || op == 3'd4) || (addr[31:5] != 27'd0) || (off > 4) ||
          (size > 3'd2) || (size == 3'd2 && addr[1:0] != 2'b00) || (op != 3'd4 && off == 1);
    for (int i = 0; i < 4; i++) bm[8*i +: 8] = mask[i] ? 8'hFF : 8'h00;
    r.opcode = (op == 3'd4) ? 3'd1 : 3'd0;
    r.err    = err;
    r.src    = src;
    r.size   = size;
    r.data   = 32'd0;
    if (!err && op == 3'd4) begin
      case (off)
        0: r.data = m_out;
        1: r.data = m_din;
        2: r.data = m_oe;
        3: r.data = m_is;
        default: r.data = m_ie;
      endcase
    end
    if (!err && op != 3'd4) begin
      case (off)
        0: m_out = (m_out & ~bm) | (data & bm);
        2: m_oe  = (m_oe & ~bm) | (data & bm);
        3: m_is  = m_is & ~(data & bm);
        4: m_ie  = (m_ie & ~bm) | (data & bm);
        default: ;
      endcase
    end
    return r;
  endfunction

  // Called on a negedge; returns on the negedge just after the accepting posedge.
  task automatic send(input logic [2:0] op, input logic [31:0] addr, input logic [3:0] mask,
                      input logic [31:0] data, input logic [1:0] src, input logic [2:0] size);
    int n;
    a_valid = 1'b1; a_opcode = op; a_address = addr; a_mask = mask; a_data = data;
    a_source = src; a_size = size; a_param = 3'd0;
    n = 0;
    while (!a_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("a_ready_wait", {63'd0, a_ready}, 64'd1);
    if (a_ready) exp_q.push_back(model_access(op, addr, mask, data, src, size));
    @(negedge clk);
    a_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || !a_ready) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("idle_wait", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic settle_gpio(input logic [31:0] v);
    gpio_in = v;
    repeat (6) @(negedge clk);
    m_is  = m_is | (v & ~m_din);
    m_din = v;
  endtask

  task automatic check_pins(input string tag);
    check({tag, "_gpio_out"}, 64'(gpio_out), 64'(m_out));
    check({tag, "_gpio_oe"}, 64'(gpio_oe), 64'(m_oe));
    check({tag, "_intr"}, {63'd0, intr}, {63'd0, |(m_is & m_ie)});
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_a_ready"}, {63'd0, a_ready}, 64'd1);
    check({tag, "_d_valid"}, {63'd0, d_valid}, 64'd0);
    check({tag, "_d_fields"}, {19'd0, d_opcode, d_param, d_error, d_data, d_source, d_size, d_sink},
          64'd0);
    check({tag, "_pins"}, {gpio_out, gpio_oe}, 64'd0);
    check({tag, "_intr"}, {63'd0, intr}, 64'd0);
  endtask

  // d_ready changes shortly after posedge so the negedge monitor sees a settled value.
  initial d_ready = 1'b1;
  always begin
    @(posedge clk);
    #2;
    case (rdy_mode)
      0:       d_ready = ($urandom_range(0, 3) != 0);
      1:       d_ready = 1'b0;
      default: d_ready = 1'b1;
    endcase
  end

  // Monitor: every cycle D is presented, it must match the scoreboard head.
  always @(negedge clk) begin
    if (reset_n && !in_reset && d_valid) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_d_beat: got d_valid=1 expected no response pending");
      end else begin
        check("d_beat", {19'd0, d_opcode, d_param, d_error, d_data, d_source, d_size, d_sink},
              {19'd0, exp_q[0].opcode, 3'd0, exp_q[0].err, exp_q[0].data, exp_q[0].src,
               exp_q[0].size, 1'b0});
        if (d_ready) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [31:0] addr;
    logic [2:0]  op, size;
    int          r;

    reset_n = 1'b0; a_valid = 1'b0; a_opcode = 0; a_param = 0; a_size = 0; a_source = 0;
    a_address = 0; a_mask = 0; a_data = 0; gpio_in = 0;
    model_reset();
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    reset_n = 1'b1;
    @(negedge clk);

    // Full put to DATA_OUT
    send(3'd0, 32'h0, 4'hF, 32'hA5A5_0F0F, 2'd2, 3'd2);
    check("put_gpio_out_next", 64'(gpio_out), 64'h0000_0000_A5A5_0F0F);
    wait_idle();

    // Partial put of byte 1 from zero, then read back
    send(3'd0, 32'h0, 4'hF, 32'h0, 2'd0, 3'd2);
    send(3'd1, 32'h0, 4'h2, 32'hFFFF_FFFF, 2'd1, 3'd2);
    check("partial_gpio_out", 64'(gpio_out), 64'h0000_0000_0000_FF00);
    send(3'd4, 32'h0, 4'hF, 32'h0, 2'd3, 3'd2);
    wait_idle();

    // Error cases leave registers alone
    send(3'd4, 32'h14, 4'hF, 32'h0, 2'd0, 3'd2);
    send(3'd6, 32'h0, 4'hF, 32'h1234_5678, 2'd1, 3'd2);
    send(3'd0, 32'h4, 4'hF, 32'hFFFF_FFFF, 2'd2, 3'd2);
    send(3'd0, 32'h2, 4'hF, 32'hFFFF_FFFF, 2'd2, 3'd2);
    send(3'd0, 32'h20, 4'hF, 32'hFFFF_FFFF, 2'd2, 3'd2);
    send(3'd4, 32'h0, 4'hF, 32'h0, 2'd0, 3'd3);
    send(3'd4, 32'h0, 4'hF, 32'h0, 2'd1, 3'd2);
    wait_idle();
    check_pins("after_errors");

    // Rising edge on gpio_in[3] with enable set
    send(3'd0, 32'h10, 4'hF, 32'h8, 2'd0, 3'd2);
    wait_idle();
    gpio_in = 32'h8;
    n = 0;
    while (!intr && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("intr_latency", 64'(n), 64'd4);
    m_is = m_is | (32'h8 & ~m_din);
    m_din = 32'h8;
    send(3'd4, 32'hC, 4'hF, 32'h0, 2'd0, 3'd2);
    send(3'd4, 32'h4, 4'hF, 32'h0, 2'd0, 3'd2);
    wait_idle();
    send(3'd0, 32'hC, 4'hF, 32'h8, 2'd0, 3'd2);
    wait_idle();
    @(negedge clk);
    check("intr_cleared", {63'd0, intr}, 64'd0);

    // Backpressure: hold d_ready low for 5 cycles
    rdy_mode = 1;
    @(negedge clk);
    send(3'd4, 32'h0, 4'hF, 32'h0, 2'd2, 3'd1);
    repeat (5) begin
      check("stall_a_ready", {63'd0, a_ready}, 64'd0);
      check("stall_d_valid", {63'd0, d_valid}, 64'd1);
      @(negedge clk);
    end
    rdy_mode = 2;
    @(negedge clk);
    @(negedge clk);
    check("a_ready_after_d", {63'd0, a_ready}, 64'd1);
    wait_idle();

    // Reset while a response is pending
    rdy_mode = 1;
    @(negedge clk);
    send(3'd0, 32'h8, 4'hF, 32'hFFFF_0000, 2'd1, 3'd2);
    check("pre_reset_d_valid", {63'd0, d_valid}, 64'd1);
    in_reset = 1'b1;
    reset_n  = 1'b0;
    #1;
    exp_q.delete();
    model_reset();
    check_reset_outputs("mid_reset");
    @(negedge clk);
    reset_n  = 1'b1;
    rdy_mode = 2;
    in_reset = 1'b0;
    repeat (5) begin
      @(negedge clk);
      check("no_stale_d", {63'd0, d_valid}, 64'd0);
    end
    settle_gpio(gpio_in);
    check_pins("post_reset");

    // Randomized traffic
    rdy_mode = 0;
    for (int it = 0; it < 300; it++) begin
      r = $urandom_range(0, 19);
      if (r == 0) begin
        wait_idle();
        settle_gpio($urandom);
      end else begin
        addr = {27'd0, 3'($urandom_range(0, 4)), 2'b00};
        size = 3'd2;
        r = $urandom_range(0, 15);
        if (r == 11) addr[4:2] = 3'($urandom_range(5, 7));
        if (r == 12) addr[31:5] = 27'($urandom_range(1, 1000));
        if (r == 13) addr[1:0] = 2'($urandom_range(1, 3));
        if (r == 14) size = 3'($urandom_range(0, 7));
        op = ($urandom_range(0, 9) < 8) ? ((r % 3 == 0) ? 3'd4 : 3'($urandom_range(0, 1)))
                                       : 3'($urandom_range(0, 7));
        send(op, addr, 4'($urandom), $urandom, 2'($urandom), size);
        wait_idle();
        check_pins("rand");
      end
    end

    wait_idle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
